// File: rtl/load_store_unit.sv
// Load/store unit: single-outstanding data bus initiator with alignment fault
// detection and one response (data or fault) per accepted request.
module load_store_unit #(
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_width,
    input  logic        req_signed,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        stall_lw,
    inout  wire  [31:0] data_bus_data,
    output logic [31:0] data_bus_addr,
    output logic [1:0]  data_bus_mode,
    output logic [1:0]  data_bus_reqw,
    output logic        data_bus_reqs
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] READ  = 2'd2;

    localparam logic [2:0] LATENCY = 3'(READ_LATENCY);

    logic [1:0]  state;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  width;
    logic        sign;
    logic [2:0]  count;
    logic        accept;
    logic        misaligned;

    assign accept = req_valid && (state == IDLE);

    // Width 11 is never legal; half and word must be naturally aligned.
    always_comb begin
        misaligned = 1'b0;
        case (req_width)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = (req_addr[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            addr       <= '0;
            wdata      <= '0;
            width      <= '0;
            sign       <= 1'b0;
            count      <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_fault <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            resp_fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr  <= req_addr;
                        wdata <= req_wdata;
                        width <= req_width;
                        sign  <= req_signed;
                        if (misaligned) begin
                            resp_valid <= 1'b1;
                            resp_fault <= 1'b1;
                            resp_rdata <= '0;
                        end else if (req_write) begin
                            state <= WRITE;
                        end else begin
                            state <= READ;
                            count <= LATENCY;
                        end
                    end
                end
                WRITE: begin
                    state      <= IDLE;
                    resp_valid <= 1'b1;
                end
                READ: begin
                    // The slave has already extended the value; take it as-is.
                    if (count == 3'd1) begin
                        resp_rdata <= data_bus_data;
                        resp_valid <= 1'b1;
                        state      <= IDLE;
                    end
                    count <= count - 3'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready     = (state == IDLE);
    assign stall_lw      = (state == READ);
    assign data_bus_mode = (state == WRITE) ? 2'b10 : (state == READ) ? 2'b01 : 2'b00;
    assign data_bus_addr = (state == IDLE) ? 32'd0 : addr;
    assign data_bus_reqw = (state == IDLE) ? 2'b00 : width;
    assign data_bus_reqs = (state == IDLE) ? 1'b0 : sign;
    assign data_bus_data = (state == WRITE) ? wdata : 32'bz;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a byte-memory slave on the shared bus, and a
// byte-array reference model that predicts every response and bus cycle.
module tb_load_store_unit;

    localparam int RL = 2;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_width;
    logic        req_signed;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic        stall_lw;
    wire  [31:0] data_bus_data;
    logic [31:0] data_bus_addr;
    logic [1:0]  data_bus_mode;
    logic [1:0]  data_bus_reqw;
    logic        data_bus_reqs;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  slave_mem [4096];
    logic [7:0]  ref_mem [4096];
    logic [31:0] last_rdata;

    load_store_unit #(.READ_LATENCY(RL)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_width(req_width),
        .req_signed(req_signed), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_fault(resp_fault), .stall_lw(stall_lw), .data_bus_data(data_bus_data),
        .data_bus_addr(data_bus_addr), .data_bus_mode(data_bus_mode),
        .data_bus_reqw(data_bus_reqw), .data_bus_reqs(data_bus_reqs)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Slave: stores on write cycles, returns extended data only in the last read cycle.
    int          rd_cnt = 0;
    logic [11:0] s_idx;
    logic [31:0] s_raw;
    logic [31:0] s_ext;
    logic        slave_en;
    logic [31:0] slave_data;

    always @(posedge clk) begin
        rd_cnt <= (data_bus_mode == 2'b01) ? rd_cnt + 1 : 0;
        if (data_bus_mode == 2'b10) begin
            slave_mem[data_bus_addr[11:0]] <= data_bus_data[7:0];
            if (data_bus_reqw != 2'b00)
                slave_mem[12'(data_bus_addr[11:0] + 12'd1)] <= data_bus_data[15:8];
            if (data_bus_reqw == 2'b10) begin
                slave_mem[12'(data_bus_addr[11:0] + 12'd2)] <= data_bus_data[23:16];
                slave_mem[12'(data_bus_addr[11:0] + 12'd3)] <= data_bus_data[31:24];
            end
        end
    end

    always_comb begin
        s_idx = data_bus_addr[11:0];
        s_raw = {slave_mem[12'(s_idx + 12'd3)], slave_mem[12'(s_idx + 12'd2)],
                 slave_mem[12'(s_idx + 12'd1)], slave_mem[s_idx]};
        s_ext = s_raw;
        case (data_bus_reqw)
            2'b00:   s_ext = data_bus_reqs ? {{24{s_raw[7]}}, s_raw[7:0]} : {24'd0, s_raw[7:0]};
            2'b01:   s_ext = data_bus_reqs ? {{16{s_raw[15]}}, s_raw[15:0]} : {16'd0, s_raw[15:0]};
            default: s_ext = s_raw;
        endcase
        slave_en   = (data_bus_mode == 2'b01);
        slave_data = (rd_cnt == RL - 1) ? s_ext : 32'hBADC0DE5;
    end

    assign data_bus_data = slave_en ? slave_data : 32'bz;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_fault(input logic [1:0] w, input logic [31:0] a);
        if (w == 2'd3) return 1'b1;
        if (w == 2'd1) return (a % 2) != 0;
        if (w == 2'd2) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic int nbytes(input logic [1:0] w);
        return (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] w, input logic sg);
        longint v;
        int     n;
        v = 0;
        n = nbytes(w);
        for (int k = n - 1; k >= 0; k--)
            v = v * 256 + longint'(ref_mem[int'((a + 32'(k)) % 4096)]);
        if (sg && n < 4 && v >= (longint'(1) << (8 * n - 1)))
            v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] w);
        for (int k = 0; k < nbytes(w); k++)
            ref_mem[int'((a + 32'(k)) % 4096)] = 8'((wd >> (8 * k)) & 32'hFF);
    endtask

    task automatic drive_req(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                             input logic [1:0] w, input logic sg);
        req_valid  = 1'b1;
        req_write  = wr;
        req_addr   = a;
        req_wdata  = wd;
        req_width  = w;
        req_signed = sg;
    endtask

    // One isolated request: every bus cycle and the response are predicted.
    task automatic applyStimulus(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                                 input logic [1:0] w, input logic sg);
        bit          flt;
        int          bus_cycles;
        logic [31:0] exp_rdata;
        flt        = is_fault(w, a);
        bus_cycles = flt ? 0 : (wr ? 1 : RL);
        @(negedge clk);
        checkOutput("idle_ready", req_ready, 1);
        checkOutput("idle_respv", resp_valid, 0);
        drive_req(wr, a, wd, w, sg);
        for (int c = 0; c <= bus_cycles; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (c < bus_cycles) begin
                checkOutput("bus_mode", data_bus_mode, wr ? 2'b10 : 2'b01);
                checkOutput("bus_addr", data_bus_addr, a);
                checkOutput("bus_reqw", data_bus_reqw, w);
                checkOutput("bus_reqs", data_bus_reqs, sg);
                checkOutput("busy_stall", stall_lw, !wr);
                checkOutput("busy_ready", req_ready, 0);
                checkOutput("busy_respv", resp_valid, 0);
                if (wr) checkOutput("bus_wdata", data_bus_data, wd);
            end
        end
        if (flt) begin
            exp_rdata = 32'd0;
        end else if (wr) begin
            exp_rdata = last_rdata;
            ref_store(a, wd, w);
        end else begin
            exp_rdata = ref_load(a, w, sg);
        end
        last_rdata = exp_rdata;
        checkOutput("resp_valid", resp_valid, 1);
        checkOutput("resp_fault", resp_fault, flt);
        checkOutput("resp_rdata", resp_rdata, exp_rdata);
        checkOutput("resp_ready", req_ready, 1);
        checkOutput("resp_mode", data_bus_mode, 2'b00);
        checkOutput("resp_stall", stall_lw, 0);
    endtask

    initial begin
        int          accept_cyc [3];
        int          k;
        int          pulses;
        logic [31:0] pulse_rdata [3];
        logic        ops_wr [3];
        logic [31:0] ops_a [3];
        logic [31:0] ops_d [3];
        logic [1:0]  ops_w [3];
        logic        wr;
        logic [31:0] a;
        logic [1:0]  w;

        for (int i = 0; i < 4096; i++) begin
            slave_mem[i] = 8'd0;
            ref_mem[i]   = 8'd0;
        end
        last_rdata = 32'd0;
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        req_width  = 2'b00;
        req_signed = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_ready", req_ready, 1);
        checkOutput("rst_respv", resp_valid, 0);
        checkOutput("rst_rdata", resp_rdata, 0);
        checkOutput("rst_fault", resp_fault, 0);
        checkOutput("rst_stall", stall_lw, 0);
        checkOutput("rst_mode", data_bus_mode, 0);
        checkOutput("rst_addr", data_bus_addr, 0);
        checkOutput("rst_reqw", data_bus_reqw, 0);
        checkOutput("rst_reqs", data_bus_reqs, 0);
        reset = 1'b1;

        applyStimulus(1'b1, 32'h3004, 32'hDEADBEEF, 2'b10, 1'b0);
        applyStimulus(1'b0, 32'h3004, 32'h0, 2'b10, 1'b0);
        checkOutput("t2_word", resp_rdata, 32'hDEADBEEF);
        applyStimulus(1'b1, 32'h3803, 32'h00000080, 2'b00, 1'b0);
        applyStimulus(1'b0, 32'h3803, 32'h0, 2'b00, 1'b1);
        checkOutput("t3_signed", resp_rdata, 32'hFFFFFF80);
        applyStimulus(1'b0, 32'h3803, 32'h0, 2'b00, 1'b0);
        checkOutput("t3_unsigned", resp_rdata, 32'h00000080);
        applyStimulus(1'b0, 32'h3001, 32'h0, 2'b01, 1'b0);
        applyStimulus(1'b0, 32'h3004, 32'h0, 2'b11, 1'b0);

        // Reset in the middle of a load must abandon it silently.
        @(negedge clk);
        drive_req(1'b0, 32'h3004, 32'h0, 2'b10, 1'b0);
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("t5_stall_before", stall_lw, 1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("t5_mode", data_bus_mode, 0);
        checkOutput("t5_stall", stall_lw, 0);
        checkOutput("t5_ready", req_ready, 1);
        checkOutput("t5_rdata", resp_rdata, 0);
        @(negedge clk);
        reset = 1'b1;
        last_rdata = 32'd0;
        for (int i = 0; i < RL + 3; i++) begin
            @(negedge clk);
            checkOutput("t5_no_resp", resp_valid, 0);
        end

        // Back-to-back with req_valid held: store, load, store.
        ops_wr = '{1'b1, 1'b0, 1'b1};
        ops_a  = '{32'h3100, 32'h3100, 32'h3102};
        ops_d  = '{32'h12345678, 32'h0, 32'h0000ABCD};
        ops_w  = '{2'b10, 2'b10, 2'b01};
        k = 0;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            accept_cyc[i]  = -1;
            pulse_rdata[i] = 32'd0;
        end
        for (int cyc = 0; cyc < 9; cyc++) begin
            @(negedge clk);
            if (resp_valid) begin
                if (pulses < 3) pulse_rdata[pulses] = resp_rdata;
                pulses++;
            end
            if (data_bus_mode == 2'b11) checkOutput("t6_mode_legal", data_bus_mode, 2'b00);
            if (req_ready && k < 3) begin
                accept_cyc[k] = cyc;
                drive_req(ops_wr[k], ops_a[k], ops_d[k], ops_w[k], 1'b0);
                k++;
            end else if (req_ready) begin
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        ref_store(32'h3100, 32'h12345678, 2'b10);
        ref_store(32'h3102, 32'h0000ABCD, 2'b01);
        checkOutput("t6_accept0", 32'(accept_cyc[0]), 32'd0);
        checkOutput("t6_accept1", 32'(accept_cyc[1]), 32'd2);
        checkOutput("t6_accept2", 32'(accept_cyc[2]), 32'(1 + 1 + 1 + RL));
        checkOutput("t6_pulses", 32'(pulses), 32'd3);
        checkOutput("t6_load", pulse_rdata[1], 32'h12345678);
        last_rdata = 32'h12345678;

        for (int n = 0; n < 60; n++) begin
            wr = 1'($urandom_range(0, 1));
            w  = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            a  = 32'h3000 + 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0 && w != 2'b11)
                a = a - (a % 32'(nbytes(w)));
            applyStimulus(wr, a, $urandom, w, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
